// File: rtl/button_reader_pkg.sv
// Shared board package: debounce FSM state encoding and press counter width,
// reused by the LED and display blocks.
package button_reader_pkg;

  localparam int PRESS_COUNT_W = 8;

  typedef logic [PRESS_COUNT_W-1:0] press_count_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

endpackage

// File: rtl/button_reader_if.sv
// Button pins in, debounced levels, pulses and running press total out.
// The master side drives the pins; the slave side is the reader.
interface button_reader_if #(
  parameter int BUTTONS = 4
);
  import button_reader_pkg::*;

  logic [BUTTONS-1:0] button;
  logic [BUTTONS-1:0] btn_state;
  logic [BUTTONS-1:0] btn_press;
  logic [BUTTONS-1:0] btn_release;
  press_count_t       press_count;

  modport master (
    output button,
    input  btn_state, btn_press, btn_release, press_count
  );

  modport slave (
    input  button,
    output btn_state, btn_press, btn_release, press_count
  );

endinterface

// File: rtl/button_reader_debounce_channel.sv
// One button channel: 2-flop synchronizer, 4-state debounce FSM and
// registered press/release pulses. DEBOUNCE_CYCLES must be at least 2.
module debounce_channel
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic hwclk,
  input  logic rst,
  input  logic pin,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int            CW           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST         = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          RELEASED_PIN = (ACTIVE_LOW != 0);

  logic [1:0]      sync_q;
  logic            level;
  debounce_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            press_q, press_d, release_q, release_d;

  // Synchronizer holds the raw pin; polarity is flipped only after it.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      sync_q <= {2{RELEASED_PIN}};
    end else begin
      sync_q <= {sync_q[0], pin};
    end
  end

  assign level = sync_q[1] ^ RELEASED_PIN;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Entering a WAIT state is the first stable sample, so the change is
  // accepted on the sample that would take the counter to LAST.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (level) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!level) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (level) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc == LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed       = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/button_reader.sv
// Debounced multi-button reader: one debounce_channel per pin plus a
// running modulo-256 total of accepted presses.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int BUTTONS         = 4,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic           hwclk,
  input  logic           rst,
  button_reader_if.slave bus
);

  logic [BUTTONS-1:0] state_vec;
  logic [BUTTONS-1:0] press_vec;
  logic [BUTTONS-1:0] release_vec;
  press_count_t       count_q;
  press_count_t       press_inc;

  for (genvar i = 0; i < BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .hwclk        (hwclk),
      .rst          (rst),
      .pin          (bus.button[i]),
      .pressed      (state_vec[i]),
      .press_pulse  (press_vec[i]),
      .release_pulse(release_vec[i])
    );
  end

  always_comb begin
    press_inc = '0;
    for (int i = 0; i < BUTTONS; i++) begin
      press_inc = press_inc + PRESS_COUNT_W'(press_vec[i]);
    end
  end

  // Wraps naturally at 256; no saturation by design.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + press_inc;
    end
  end

  assign bus.btn_state   = state_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;
  assign bus.press_count = count_q;

endmodule
